// File: rtl/ntt_pkg.sv
// Shared NTT constants, the coefficient type and the modular add/sub used by
// the butterfly completion stage.
package ntt_pkg;

  localparam int M       = 12289;
  localparam int M_WIDTH = 14;
  localparam int RED_LAT = 3;

  typedef logic [M_WIDTH-1:0] coeff_t;
  typedef logic [M_WIDTH:0]   wide_t;

  localparam wide_t M_W = wide_t'(M);

  // Packed pair so it can travel through a plain-vector FIFO unchanged.
  typedef struct packed {
    coeff_t x;
    coeff_t y;
  } bf_out_t;

  // x = (a+z) mod M, y = (a-z) mod M. The reducer may legally emit z == M,
  // which is folded to 0 first so both results land in [0, M-1].
  function automatic bf_out_t mod_addsub(coeff_t a, coeff_t z);
    wide_t   zn;
    wide_t   s;
    wide_t   d;
    bf_out_t r;
    zn  = ({1'b0, z} == M_W) ? '0 : {1'b0, z};
    s   = {1'b0, a} + zn;
    d   = {1'b0, a} - zn;
    r.x = (s >= M_W) ? coeff_t'(s - M_W) : coeff_t'(s);
    // Bit M_WIDTH is the sign of the difference since |a - z'| < 2^M_WIDTH.
    r.y = d[M_WIDTH] ? coeff_t'(d + M_W) : coeff_t'(d);
    return r;
  endfunction

endpackage

// File: rtl/ntt_bf_addsub_if.sv
// Output stream of the butterfly stage.
// Handshake: the producer holds out_x/out_y stable while out_valid is high;
// a transfer happens on every rising clk edge where out_valid && out_ready.
// out_ready is ignored while out_valid is low.
interface ntt_bf_addsub_if;
  import ntt_pkg::*;

  coeff_t out_x;
  coeff_t out_y;
  logic   out_valid;
  logic   out_ready;

  modport master (output out_x, output out_y, output out_valid, input out_ready);
  modport slave  (input out_x, input out_y, input out_valid, output out_ready);

endinterface

// File: rtl/ntt_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count. A write while full is
// accepted only if a read happens in the same cycle; otherwise it is dropped.
module ntt_sync_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_wr_en;
  logic             w_rd_en;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign w_rd_en = i_rd && !o_empty;
  // When full, the slot being written is the head that is leaving this cycle.
  assign w_wr_en = i_wr && (!o_full || w_rd_en);
  // Head is forced to zero when empty so stale storage never shows.
  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage array: written only on an accepted write, needs no reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_rd_en) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ntt_bf_addsub.sv
// Butterfly completion: aligns coefficient a with the reducer output z,
// computes (a+z) mod M and (a-z) mod M, and buffers results in an output FIFO.
// The reducer cannot be stalled, so issue_stall tells the issue controller to
// stop early enough that everything already in flight still fits.
// FIFO_DEPTH must be at least LAT+3.
module ntt_bf_addsub
  import ntt_pkg::*;
#(
  parameter int LAT        = RED_LAT,
  parameter int FIFO_DEPTH = 8,
  localparam int LEVEL_W   = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  coeff_t             a_in,
  input  logic               a_valid,
  input  coeff_t             z_in,
  input  logic               z_valid,
  ntt_bf_addsub_if.master    out_if,
  output logic               issue_stall,
  output logic [LEVEL_W-1:0] level,
  output logic               overflow,
  output logic               align_err
);

  coeff_t             r_a_dly [LAT];
  logic [LAT-1:0]     r_v_dly;
  bf_out_t            r_res;
  logic               r_cv;
  logic               r_overflow;
  logic               r_align_err;
  bf_out_t            w_bf;
  bf_out_t            w_head;
  logic               w_rd;
  logic               w_full;
  logic               w_empty;
  logic [LEVEL_W-1:0] w_count;

  assign w_bf = mod_addsub(r_a_dly[LAT-1], z_in);

  // Delay line for {a, a_valid}; free-running so stage LAT-1 meets z_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) r_a_dly[i] <= '0;
      r_v_dly <= '0;
    end else begin
      r_a_dly[0] <= a_in;
      r_v_dly[0] <= a_valid;
      for (int i = 1; i < LAT; i++) begin
        r_a_dly[i] <= r_a_dly[i-1];
        r_v_dly[i] <= r_v_dly[i-1];
      end
    end
  end

  // Compute register, loaded whenever the reducer presents a result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cv  <= 1'b0;
      r_res <= '0;
    end else begin
      r_cv <= z_valid;
      if (z_valid) r_res <= w_bf;
    end
  end

  // Sticky error flags: dropped write, and z without a matching delayed a.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_align_err <= 1'b0;
    end else begin
      if (r_cv && w_full && !w_rd)          r_overflow  <= 1'b1;
      if (z_valid && !r_v_dly[LAT-1])       r_align_err <= 1'b1;
    end
  end

  assign w_rd = out_if.out_valid && out_if.out_ready;

  ntt_sync_fifo #(
    .WIDTH (2 * M_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr    (r_cv),
    .i_wdata (r_res),
    .i_rd    (w_rd),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign out_if.out_valid = !w_empty;
  assign out_if.out_x     = w_head.x;
  assign out_if.out_y     = w_head.y;
  assign level            = w_count;
  // At most LAT+1 items can still land after stall rises: LAT in the delay
  // line plus one in the compute register.
  assign issue_stall      = (w_count >= LEVEL_W'(FIFO_DEPTH - LAT - 2));
  assign overflow         = r_overflow;
  assign align_err        = r_align_err;

endmodule

// File: tb/tb_ntt_bf_addsub.sv
// Directed bench for ntt_bf_addsub; the bench plays the role of the reducer
// with a LAT-deep pipeline of z values.
module tb_ntt_bf_addsub;
  import ntt_pkg::*;

  localparam int LAT   = 3;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  coeff_t     a_in = '0;
  coeff_t     z_in = '0;
  logic       a_valid = 1'b0;
  logic       z_valid = 1'b0;
  logic       issue_stall;
  logic       overflow;
  logic       align_err;
  logic [3:0] level;

  int checks   = 0;
  int failures = 0;

  coeff_t pz [LAT];
  logic   pv [LAT];
  logic [2*M_WIDTH-1:0] exp_q [$];

  ntt_bf_addsub_if u_if ();

  ntt_bf_addsub #(.LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_in        (a_in),
    .a_valid     (a_valid),
    .z_in        (z_in),
    .z_valid     (z_valid),
    .out_if      (u_if),
    .issue_stall (issue_stall),
    .level       (level),
    .overflow    (overflow),
    .align_err   (align_err)
  );

  // clock
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_pipe();
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pz[i] = '0;
    end
  endtask

  // One clock: drive a (and the reducer tail), then advance the reducer model.
  task automatic step(input logic v, input coeff_t a, input coeff_t z);
    a_valid = v;
    a_in    = a;
    z_valid = pv[LAT-1];
    z_in    = pz[LAT-1];
    @(posedge clk);
    #1;
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pz[i] = pz[i-1];
    end
    pv[0] = v;
    pz[0] = z;
  endtask

  // One clock with a reducer output that has no matching issue.
  task automatic step_inject(input coeff_t z);
    a_valid = 1'b0;
    a_in    = '0;
    z_valid = 1'b1;
    z_in    = z;
    @(posedge clk);
    #1;
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pz[i] = pz[i-1];
    end
    pv[0] = 1'b0;
    pz[0] = '0;
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    a_valid = 1'b0;
    z_valid = 1'b0;
    a_in    = '0;
    z_in    = '0;
    u_if.out_ready = 1'b0;
    clear_pipe();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [35:0] obs;
    u_if.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    clear_pipe();
    repeat (2) @(posedge clk);
    #1;
    obs = {u_if.out_valid, u_if.out_x, u_if.out_y, level, issue_stall, overflow, align_err};
    checks++;
    if (obs !== 36'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", obs);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    u_if.out_ready = 1'b1;
    step(1'b1, 14'd5, 14'd7);
    repeat (3) step(1'b0, '0, '0);
    checks++;
    if (u_if.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_early_valid got=%b exp=0", u_if.out_valid);
    end
    step(1'b0, '0, '0);
    checks++;
    if ({u_if.out_valid, u_if.out_x, u_if.out_y, level} !== {1'b1, 14'd12, 14'd12287, 4'd1}) begin
      failures++;
      $display("FAIL basic_result got v=%b x=%0d y=%0d lvl=%0d exp v=1 x=12 y=12287 lvl=1",
               u_if.out_valid, u_if.out_x, u_if.out_y, level);
    end
    step(1'b0, '0, '0);
    checks++;
    if ({u_if.out_valid, level} !== {1'b0, 4'd0}) begin
      failures++;
      $display("FAIL basic_drain got v=%b lvl=%0d exp v=0 lvl=0", u_if.out_valid, level);
    end
  endtask

  task automatic test_edges();
    u_if.out_ready = 1'b1;
    step(1'b1, 14'd12288, 14'd12288);
    step(1'b1, 14'd0, 14'd1);
    repeat (3) step(1'b0, '0, '0);
    checks++;
    if ({u_if.out_valid, u_if.out_x, u_if.out_y} !== {1'b1, 14'd12287, 14'd0}) begin
      failures++;
      $display("FAIL edge_max got v=%b x=%0d y=%0d exp v=1 x=12287 y=0",
               u_if.out_valid, u_if.out_x, u_if.out_y);
    end
    step(1'b0, '0, '0);
    checks++;
    if ({u_if.out_valid, u_if.out_x, u_if.out_y} !== {1'b1, 14'd1, 14'd12288}) begin
      failures++;
      $display("FAIL edge_wrap got v=%b x=%0d y=%0d exp v=1 x=1 y=12288",
               u_if.out_valid, u_if.out_x, u_if.out_y);
    end
    step(1'b0, '0, '0);
    checks++;
    if (u_if.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL edge_drain got v=%b exp=0", u_if.out_valid);
    end
  endtask

  task automatic test_unreduced();
    u_if.out_ready = 1'b1;
    step(1'b1, 14'd100, 14'd12289);
    repeat (4) step(1'b0, '0, '0);
    checks++;
    if ({u_if.out_valid, u_if.out_x, u_if.out_y, align_err} !== {1'b1, 14'd100, 14'd100, 1'b0}) begin
      failures++;
      $display("FAIL unreduced_z got v=%b x=%0d y=%0d ae=%b exp v=1 x=100 y=100 ae=0",
               u_if.out_valid, u_if.out_x, u_if.out_y, align_err);
    end
    step(1'b0, '0, '0);
  endtask

  task automatic test_stall_honoured();
    int issued;
    int peak;
    coeff_t a;
    coeff_t z;
    issued = 0;
    peak   = 0;
    exp_q.delete();
    u_if.out_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (!issue_stall) begin
        a = coeff_t'(issued * 10 + 20);
        z = coeff_t'(issued + 1);
        exp_q.push_back({coeff_t'(a + z), coeff_t'(a - z)});
        step(1'b1, a, z);
        issued++;
      end else begin
        step(1'b0, '0, '0);
      end
      if (int'(level) > peak) peak = int'(level);
    end
    checks++;
    if (issued != 7) begin
      failures++;
      $display("FAIL stall_issue_count got=%0d exp=7", issued);
    end
    checks++;
    if (peak > 7 || overflow !== 1'b0 || level !== 4'd7) begin
      failures++;
      $display("FAIL stall_fill got peak=%0d ovf=%b lvl=%0d exp peak<=7 ovf=0 lvl=7",
               peak, overflow, level);
    end
    u_if.out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      logic [2*M_WIDTH-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if ({u_if.out_valid, u_if.out_x, u_if.out_y} !== {1'b1, e}) begin
        failures++;
        $display("FAIL stall_drain[%0d] got v=%b x=%0d y=%0d exp v=1 x=%0d y=%0d",
                 k, u_if.out_valid, u_if.out_x, u_if.out_y, e[27:14], e[13:0]);
      end
      step(1'b0, '0, '0);
    end
    checks++;
    if ({u_if.out_valid, level} !== {1'b0, 4'd0}) begin
      failures++;
      $display("FAIL stall_empty got v=%b lvl=%0d exp v=0 lvl=0", u_if.out_valid, level);
    end
  endtask

  task automatic test_overflow();
    coeff_t a;
    coeff_t z;
    int     y;
    apply_reset();
    exp_q.delete();
    u_if.out_ready = 1'b0;
    for (int s = 0; s < 13; s++) begin
      if (s < 10) begin
        a = coeff_t'(s * 100 + 3);
        z = coeff_t'(s + 50);
        y = (int'(a) >= int'(z)) ? int'(a) - int'(z) : int'(a) + M - int'(z);
        if (s != 8) exp_q.push_back({coeff_t'(a + z), coeff_t'(y)});
        step(1'b1, a, z);
      end else begin
        step(1'b0, '0, '0);
      end
      if (s == 11) begin
        checks++;
        if ({level, overflow} !== {4'd8, 1'b0}) begin
          failures++;
          $display("FAIL ovf_full got lvl=%0d ovf=%b exp lvl=8 ovf=0", level, overflow);
        end
      end
      if (s == 12) begin
        checks++;
        if ({level, overflow} !== {4'd8, 1'b1}) begin
          failures++;
          $display("FAIL ovf_drop got lvl=%0d ovf=%b exp lvl=8 ovf=1", level, overflow);
        end
      end
    end
    u_if.out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      logic [2*M_WIDTH-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if ({u_if.out_valid, u_if.out_x, u_if.out_y} !== {1'b1, e}) begin
        failures++;
        $display("FAIL ovf_entry[%0d] got v=%b x=%0d y=%0d exp v=1 x=%0d y=%0d",
                 k, u_if.out_valid, u_if.out_x, u_if.out_y, e[27:14], e[13:0]);
      end
      step(1'b0, '0, '0);
      if (k == 0) begin
        checks++;
        if ({level, issue_stall} !== {4'd8, 1'b1}) begin
          failures++;
          $display("FAIL ovf_rw_full got lvl=%0d stall=%b exp lvl=8 stall=1", level, issue_stall);
        end
      end
    end
    checks++;
    if ({u_if.out_valid, level} !== {1'b0, 4'd0}) begin
      failures++;
      $display("FAIL ovf_empty got v=%b lvl=%0d exp v=0 lvl=0", u_if.out_valid, level);
    end
  endtask

  task automatic test_align_and_reset();
    logic [35:0] obs;
    apply_reset();
    u_if.out_ready = 1'b0;
    step_inject(14'd5);
    checks++;
    if (align_err !== 1'b1) begin
      failures++;
      $display("FAIL align_err got=%b exp=1", align_err);
    end
    step(1'b0, '0, '0);
    checks++;
    if ({u_if.out_valid, u_if.out_x, u_if.out_y} !== {1'b1, 14'd5, 14'd12284}) begin
      failures++;
      $display("FAIL align_entry got v=%b x=%0d y=%0d exp v=1 x=5 y=12284",
               u_if.out_valid, u_if.out_x, u_if.out_y);
    end
    step(1'b1, 14'd11, 14'd2);
    step(1'b1, 14'd12, 14'd3);
    step(1'b1, 14'd13, 14'd4);
    a_valid = 1'b0;
    z_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    obs = {u_if.out_valid, u_if.out_x, u_if.out_y, level, issue_stall, overflow, align_err};
    checks++;
    if (obs !== 36'd0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=0", obs);
    end
    clear_pipe();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    u_if.out_ready = 1'b1;
    step(1'b1, 14'd20, 14'd30);
    repeat (3) step(1'b0, '0, '0);
    checks++;
    if ({u_if.out_valid, level} !== {1'b0, 4'd0}) begin
      failures++;
      $display("FAIL post_reset_early got v=%b lvl=%0d exp v=0 lvl=0", u_if.out_valid, level);
    end
    step(1'b0, '0, '0);
    checks++;
    if ({u_if.out_valid, u_if.out_x, u_if.out_y, align_err} !== {1'b1, 14'd50, 14'd12279, 1'b0}) begin
      failures++;
      $display("FAIL post_reset_item got v=%b x=%0d y=%0d ae=%b exp v=1 x=50 y=12279 ae=0",
               u_if.out_valid, u_if.out_x, u_if.out_y, align_err);
    end
    step(1'b0, '0, '0);
  endtask

  initial begin
    u_if.out_ready = 1'b0;
    clear_pipe();
    test_reset();
    test_basic();
    test_edges();
    test_unreduced();
    test_stall_honoured();
    test_overflow();
    test_align_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ntt_bf_addsub.md
Name: ntt_bf_addsub

Overview:
- Downstream neighbour of the Barrett reduction stage in the NTT datapath.
- Completes a Cooley-Tukey butterfly: takes reduced product z = b·w mod M from the reducer, and the matching coefficient a delayed internally to the reducer latency.
- Emits x = (a+z) mod M and y = (a−z) mod M through an output FIFO with ready/valid.
- Drives a stall flag back to the issue controller, because the reducer pipeline has no backpressure.

Parameters:
- M, 12289, NTT modulus.
- M_WIDTH, 14, coefficient width (= $clog2(M)).
- LAT, 3, reducer latency in cycles from its valid_in to its valid_out.
- FIFO_DEPTH, 8, output FIFO entries; must satisfy FIFO_DEPTH ≥ LAT+3.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- a_in  in  M_WIDTH  coefficient a; presented the same cycle its product U enters the reducer
- a_valid  in  1  qualifies a_in; same cycle as reducer valid_in
- z_in  in  M_WIDTH  reducer output Z
- z_valid  in  1  reducer valid_out
- out_x  out  M_WIDTH  (a+z) mod M, FIFO head
- out_y  out  M_WIDTH  (a−z) mod M, FIFO head
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head
- issue_stall  out  1  upstream must not assert a_valid / reducer valid_in while high
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky: a write was dropped
- align_err  out  1  sticky: z_valid arrived without a matching delayed a_valid

Behaviour:
- Interface decided: single clock clk; rst_n asynchronous, active-low.
- Reset: all outputs 0; FIFO empty; delay line cleared. Reset mid-operation discards in-flight data and FIFO contents.
- Delay line: LAT-stage shift register of {a_in, a_valid}, shifting every cycle with no enable. The tap at stage LAT aligns with z_valid.
- align_err: set when z_valid=1 and delayed a_valid=0. The entry is still computed with the delayed a value.
- Input ranges:
  - z_in ∈ [0, M]. The value M, which the reducer can legally emit, is normalised to 0 before arithmetic.
  - a_in < M is required; it is not checked.
- Compute stage (one register, enabled by z_valid):
  - s = a+z' in M_WIDTH+1 bits; x = (s ≥ M) ? s−M : s.
  - d = a−z' signed in M_WIDTH+1 bits; y = (d < 0) ? d+M : d.
  - Both results are always in [0, M−1].
- FIFO:
  - Show-ahead; out_x/out_y valid whenever out_valid=1.
  - Write on registered compute-valid; read on out_valid && out_ready.
  - Simultaneous read and write: both happen, level unchanged, including when full.
  - Write while full with no read: data dropped, overflow←1 (cleared only by reset).
  - Read when empty: impossible, since out_ready is ignored while out_valid=0.
- Latency: a_valid at cycle t → z_valid at t+LAT → compute register at t+LAT+1 → out_valid=1 at t+LAT+2 (FIFO empty, out_ready=1). Throughput is 1 per cycle.
- issue_stall:
  - Combinational: level ≥ FIFO_DEPTH−LAT−2 (=3 at defaults).
  - This guarantees no overflow when upstream honours it in the same cycle: at most LAT+1 items are in flight.
- level: updates on the cycle after a write or read; stays in [0, FIFO_DEPTH].

Decomposition:
- Package ntt_pkg: M, M_WIDTH, coeff_t (logic [M_WIDTH-1:0]), RED_LAT=3, plus a function mod_addsub(a,z) returning {x,y}. The function is shared with the bench model.
- One sub-module: ntt_sync_fifo, parameterised on width and depth, with async active-low reset, show-ahead, count output, and full/empty.

Test Plan:
- a=5, z=7, out_ready=1, a_valid at t → out_valid at t+5 with x=12, y=12287; level returns to 0.
- a=12288, z=12288 → x=12287, y=0; then a=0, z=1 → x=1, y=12288.
- a=100, z_in=12289 (unreduced) → x=100, y=100, no align_err.
- out_ready=0, back-to-back issue honouring issue_stall → level peaks ≤ 7, overflow stays 0. Then raise out_ready → entries drain in issue order, one per cycle.
- out_ready=0, issue 9 items ignoring issue_stall → overflow=1 on 9th write, level=8, first 8 entries intact. A simultaneous read+write at full → level stays 8, no overflow.
- z_valid pulse with no a_valid LAT cycles earlier → align_err=1. Then rst_n low mid-stream → all outputs 0 asynchronously; after release the first new item emerges at t+5.
